// File: rtl/soft_stop_if.sv
// soft_stop_if: groups the shutdown request and the PWM-facing outputs of soft_stop.
// master drives the request side (controller/testbench); slave is the soft_stop block.
interface soft_stop_if;
  logic       i_start;
  logic [7:0] i_duty_init;
  logic [7:0] o_duty_sel;
  logic       o_enable;
  logic       o_busy;
  logic       o_done;

  modport master (
    output i_start,
    output i_duty_init,
    input  o_duty_sel,
    input  o_enable,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_start,
    input  i_duty_init,
    output o_duty_sel,
    output o_enable,
    output o_busy,
    output o_done
  );
endinterface

// File: rtl/soft_stop.sv
// soft_stop: ramps the PWM duty code down to zero, one code per CONST_TS*NUM_CYCLES clocks,
// after a level shutdown request. Optional macro SOFT_STOP_ABORT_EN lets a dropped request
// abandon the ramp and return to idle; without it the ramp always runs to completion.
module soft_stop #(
  parameter logic [7:0]  DUTY_LIM   = 8'd184,
  parameter logic [9:0]  CONST_TS   = 10'd1000,
  parameter logic [20:0] NUM_CYCLES = 21'd15000
) (
  input logic        i_clk,
  input logic        reset,
  soft_stop_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRamp = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [7:0]  duty_q, duty_d;
  logic [9:0]  presc_q, presc_d;
  logic [20:0] tick_q, tick_d;
  logic [7:0]  duty_load;
  logic        presc_wrap;
  logic        tick_wrap;

  // Clamp the requested starting duty to the permitted maximum.
  always_comb begin
    duty_load = (bus.i_duty_init > DUTY_LIM) ? DUTY_LIM : bus.i_duty_init;
  end

  // Next-state logic: sequencing, prescaler, tick counter and duty decrement.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    presc_d    = presc_q;
    tick_d     = tick_q;
    presc_wrap = (presc_q == CONST_TS - 10'd1);
    tick_wrap  = (tick_q == NUM_CYCLES - 21'd1);
    case (state_q)
      StIdle: begin
        presc_d = '0;
        tick_d  = '0;
        duty_d  = '0;
        if (bus.i_start) begin
          duty_d  = duty_load;
          state_d = (duty_load != 8'd0) ? StRamp : StDone;
        end
      end
      StRamp: begin
        if (presc_wrap) begin
          presc_d = '0;
          if (tick_wrap) begin
            tick_d = '0;
            duty_d = duty_q - 8'd1;
            // Last step lands on zero: leave RAMP on the same edge so duty never reads 0 here.
            if (duty_q == 8'd1) begin
              state_d = StDone;
            end
          end else begin
            tick_d = tick_q + 21'd1;
          end
        end else begin
          presc_d = presc_q + 10'd1;
        end
`ifdef SOFT_STOP_ABORT_EN
        if (!bus.i_start) begin
          state_d = StIdle;
          duty_d  = '0;
          presc_d = '0;
          tick_d  = '0;
        end
`endif
      end
      StDone: begin
        duty_d  = '0;
        presc_d = '0;
        tick_d  = '0;
        if (!bus.i_start) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        duty_d  = '0;
        presc_d = '0;
        tick_d  = '0;
      end
    endcase
  end

  // State registers; reset clears everything immediately, independent of the clock.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      duty_q  <= '0;
      presc_q <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.o_duty_sel = (state_q == StRamp) ? duty_q : 8'd0;
    bus.o_enable   = (state_q == StRamp);
    bus.o_busy     = (state_q == StRamp);
    bus.o_done     = (state_q == StDone);
  end

endmodule

// File: doc/soft_stop.md
SOFT_STOP -- requirements
Module: soft_stop

Interface
REQ-001 Parameter DUTY_LIM, default 8'd184, maximum duty code accepted at ramp start.
REQ-002 Parameter CONST_TS, default 1000, prescaler length in clocks (width 10).
REQ-003 Parameter NUM_CYCLES, default 15000, prescaler ticks per duty step (width 21).
REQ-004 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 i_start  input  1  level request to ramp duty down; held high for the whole shutdown.
REQ-007 i_duty_init  input  8  duty code in force when shutdown begins; sampled once at start.
REQ-008 o_duty_sel  output  8  current duty code to PWM stage.
REQ-009 o_enable  output  1  PWM enable; high only while ramping with nonzero duty.
REQ-010 o_busy  output  1  high while in RAMP.
REQ-011 o_done  output  1  ramp-down complete.

Function
REQ-012 States: IDLE, RAMP, DONE; registered state, one-hot or binary at implementer's choice.
REQ-013 IDLE: o_duty_sel=0, o_busy=0, o_done=0, o_enable=0.
REQ-014 IDLE with i_start=1 at edge: load duty register with min(i_duty_init, DUTY_LIM); go RAMP if loaded value >0, else go DONE.
REQ-015 On RAMP entry, prescaler and tick counter SHALL be cleared so the first step occurs exactly CONST_TS*NUM_CYCLES clocks after entry.
REQ-016 Prescaler counts CONST_TS clocks per tick; tick counter counts NUM_CYCLES ticks per step; both wrap to start after each step.
REQ-017 Each step decrements duty register by exactly 1; no underflow: decrement from 1 yields 0 and state goes DONE on the same edge.
REQ-018 RAMP: o_duty_sel = duty register, o_busy=1, o_enable=1 (duty always >0 in RAMP).
REQ-019 DONE: o_duty_sel=0, o_done=1, o_enable=0, o_busy=0; stays until i_start=0, then IDLE next edge.
REQ-020 i_duty_init changes after the start edge SHALL have no effect.
REQ-021 Step period SHALL be CONST_TS*NUM_CYCLES clocks exactly; full ramp from D takes D*CONST_TS*NUM_CYCLES clocks.
REQ-022 All outputs registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-023 reset=1 SHALL immediately force IDLE, duty register 0, both counters 0, all outputs 0, irrespective of clock.
REQ-024 Reset mid-RAMP SHALL abandon the ramp; after release, a new shutdown needs i_start sampled high in IDLE.

Configuration
REQ-025 Macro SOFT_STOP_ABORT_EN defined: i_start=0 sampled in RAMP returns to IDLE next edge (duty 0, counters cleared, o_done not asserted).
REQ-026 SOFT_STOP_ABORT_EN undefined: i_start is ignored in RAMP; ramp always runs to DONE; DONE exit still requires i_start=0.

Verification (bench parameters CONST_TS=4, NUM_CYCLES=2, step=8 clocks)
REQ-027 i_duty_init=3, i_start high -> o_duty_sel 3 for 8 clocks, 2 for 8, 1 for 8, then 0 with o_done=1 at clock 24 after RAMP entry; o_enable low from same edge.
REQ-028 i_duty_init=200 -> loaded value 184; o_duty_sel reads 184 on RAMP entry, 183 after 8 clocks.
REQ-029 i_duty_init=0, i_start high -> DONE next edge, o_busy never high, o_enable never high.
REQ-030 reset pulsed asynchronously (between clock edges) at duty 100 in RAMP -> all outputs 0 before next edge; IDLE after release.
REQ-031 With SOFT_STOP_ABORT_EN, i_start dropped at duty 5 -> IDLE next edge, o_duty_sel=0, o_done=0; without macro, ramp continues to 0 and o_done=1, then IDLE one edge later.
REQ-032 i_start held high in DONE for 20 clocks -> o_done stays 1; i_start low -> IDLE next edge; i_start high again -> new ramp starts.
